jk_ff_checker: RTL and testbench
================================

# jk_ff_checker

Synthesizable conformance monitor that sits on the far side of a JK flip-flop: it observes the flop's J, K, its active-high reset and its Q output, predicts each next-state, and flags any mismatch. Per-mode coverage counters and an error counter are kept, and a sticky fail state is entered on reaching an error limit. It is used in self-checking benches and as an on-chip sanity monitor beside any `jk_ff` instance.

## Interface
- `CNT_W`, 16: width of every coverage/error counter (saturating).
- `ERR_LIMIT`, 1: error count at which the checker enters FAIL (1..2^CNT_W-1).

- `clk`  in  1  same clock as the observed flop; sampling on rising edge.
- `reset`  in  1  asynchronous, active-low checker reset.
- `en`  in  1  checking enabled; low returns checker to IDLE (counters held).
- `clear`  in  1  synchronous: zero all counters, clear `err`, go to IDLE; wins over everything but `reset`.
- `dut_rst`  in  1  observed flop's reset (active-high, synchronous to `clk`).
- `J`, `K`  in  1 each  observed flop inputs.
- `Q`  in  1  observed flop output.
- `hold_cnt`, `rst_cnt`, `set_cnt`, `tog_cnt`  out  CNT_W  checked transitions per mode.
- `dres_cnt`  out  CNT_W  checked DUT-reset transitions.
- `err_cnt`  out  CNT_W  mismatches detected.
- `err`  out  1  sticky, set on first mismatch.
- `first_err_mode`  out  2  {J,K} of first failing transition; `dut_rst` failures report 2'b01.
- `fail`  out  1  high in FAIL state.

All outputs reset to 0.

## Operation
- Mode = {J,K}: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- Each rising edge samples `dut_rst`, J, K, Q (Q is the pre-update value). Expected next Q: 0 if `dut_rst`, else Q / 0 / 1 / ~Q per mode. Stored with the sampled mode.
- Next edge: sampled Q compared with stored expectation.
  - Match: increment `dres_cnt` if stored `dut_rst`, else the counter of the stored mode.
  - Mismatch: increment `err_cnt`; if `err` was 0, set `err` and load `first_err_mode`.
- States:
  - IDLE: no capture, no compare. Goes to PRIME when `en`=1.
  - PRIME: capture only. Goes to CHECK.
  - CHECK: compare then capture every cycle. Goes to IDLE when `en`=0. Goes to FAIL when the increment makes `err_cnt` equal `ERR_LIMIT`.
  - FAIL: counters frozen, `fail`=1. Exits only via `clear` or `reset`.
- Counters saturate at 2^CNT_W-1. Saturation of `err_cnt` does not clear `err`.
- `en` low in CHECK: that edge performs no compare. The pending expectation is discarded, and re-enable goes through PRIME.
- `clear` and `en` high on the same edge: clear applies, next state IDLE, then PRIME on the following edge.
- `reset` asserted mid-check: all state and outputs are 0 immediately. The first compare after release happens on the second enabled edge.

## Timing
- Compare latency: a transition launched by the inputs sampled at edge t is checked at edge t+1. Counters and `err` update at t+1 and are visible after it.
- `fail` asserts in the same cycle that `err_cnt` reaches `ERR_LIMIT`.
- No combinational path from inputs to outputs.

## Structure
- Package `jk_pkg`:
  - `jk_mode_t` (2-bit: HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11).
  - `chk_state_t` (IDLE, PRIME, CHECK, FAIL).
  - Function `jk_next(mode, q)` for the expected next state.
- Sub-module `jk_sat_counter`:
  - Parameter CNT_W; ports clk, reset, clr, inc, cnt.
  - Instantiated six times.

## Test plan
- DUT reset 1 cycle, then J/K = 00, 01, 10, 11, 11 with a correct `jk_ff` and `en`=1 throughout → after final compare: `dres_cnt`=1, `hold_cnt`=1, `rst_cnt`=1, `set_cnt`=1, `tog_cnt`=2, `err_cnt`=0, `err`=0.
- Correct flop, but Q forced to 0 on the second TOGGLE cycle, `ERR_LIMIT`=1 → `err_cnt`=1, `err`=1, `first_err_mode`=2'b11, `fail`=1 on that edge. Further stimulus leaves all counters unchanged.
- `CNT_W`=3, 10 consecutive HOLD transitions → `hold_cnt`=7, no other counter changes.
- `en` dropped for 2 cycles mid-stream while J=1,K=1 → no count during the gap. The first re-enabled edge is PRIME with no count, and `tog_cnt` resumes on the following edge.
- `reset` pulsed low for half a cycle during CHECK with nonzero counters → all outputs 0 asynchronously. First count occurs on the second enabled edge after release.
- In FAIL, assert `clear` → all counters 0, `err`=0, `fail`=0, state IDLE. PRIME on the next edge, and counting resumes the edge after.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and the JK next-state rule used by the JK flip-flop conformance checker.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    CHECK = 2'b10,
    FAIL  = 2'b11
  } chk_state_t;

  function automatic logic jk_next(input jk_mode_t mode, input logic q);
    logic r_q;
    case (mode)
      HOLD:    r_q = q;
      RESET:   r_q = 1'b0;
      SET:     r_q = 1'b1;
      TOGGLE:  r_q = ~q;
      default: r_q = q;
    endcase
    return r_q;
  endfunction

endpackage

// File: rtl/jk_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset and synchronous clear.
module jk_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/jk_ff_checker.sv
// Conformance monitor for a JK flip-flop: predicts each next Q, compares it one edge later,
// keeps per-mode coverage and error counts, and latches a FAIL state at the error limit.
module jk_ff_checker
  import jk_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int ERR_LIMIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             dut_rst,
  input  logic             J,
  input  logic             K,
  input  logic             Q,
  output logic [CNT_W-1:0] hold_cnt,
  output logic [CNT_W-1:0] rst_cnt,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] tog_cnt,
  output logic [CNT_W-1:0] dres_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic [1:0]       first_err_mode,
  output logic             fail
);

  chk_state_t       r_state;
  chk_state_t       w_state_nxt;
  logic             r_exp_q;
  logic             r_exp_dres;
  jk_mode_t         r_exp_mode;
  logic             r_err;
  logic [1:0]       r_first_err_mode;
  logic             w_capture;
  logic             w_compare;
  logic             w_mismatch;
  logic             w_good;
  logic             w_inc_hold;
  logic             w_inc_rst;
  logic             w_inc_set;
  logic             w_inc_tog;
  logic             w_inc_dres;
  logic             w_inc_err;
  logic [CNT_W-1:0] w_err_next;
  logic             w_limit_hit;

  assign w_mismatch  = (Q != r_exp_q);
  assign w_good      = w_compare && !w_mismatch;
  assign w_inc_err   = w_compare && w_mismatch;
  assign w_inc_dres  = w_good && r_exp_dres;
  assign w_inc_hold  = w_good && !r_exp_dres && (r_exp_mode == HOLD);
  assign w_inc_rst   = w_good && !r_exp_dres && (r_exp_mode == RESET);
  assign w_inc_set   = w_good && !r_exp_dres && (r_exp_mode == SET);
  assign w_inc_tog   = w_good && !r_exp_dres && (r_exp_mode == TOGGLE);
  // The limit is tested against the post-increment value so FAIL lands on the same edge.
  assign w_err_next  = (err_cnt == {CNT_W{1'b1}}) ? err_cnt : (err_cnt + CNT_W'(1));
  assign w_limit_hit = w_inc_err && (w_err_next == CNT_W'(ERR_LIMIT));

  // Next-state and capture/compare strobes; the edge leaving IDLE captures the first expectation.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_compare   = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_capture   = 1'b1;
          w_state_nxt = PRIME;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PRIME, CHECK: begin
        if (en) begin
          w_compare   = 1'b1;
          w_capture   = 1'b1;
          w_state_nxt = w_limit_hit ? FAIL : CHECK;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FAIL: begin
        w_state_nxt = FAIL;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (clear) begin
      w_state_nxt = IDLE;
      w_capture   = 1'b0;
      w_compare   = 1'b0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Checker state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending expectation: Q predicted for the next edge, with the mode that launched it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exp_q    <= 1'b0;
      r_exp_dres <= 1'b0;
      r_exp_mode <= HOLD;
    end else if (clear) begin
      r_exp_q    <= 1'b0;
      r_exp_dres <= 1'b0;
      r_exp_mode <= HOLD;
    end else if (w_capture) begin
      r_exp_q    <= dut_rst ? 1'b0 : jk_next(jk_mode_t'({J, K}), Q);
      r_exp_dres <= dut_rst;
      r_exp_mode <= jk_mode_t'({J, K});
    end else begin
      r_exp_q    <= r_exp_q;
      r_exp_dres <= r_exp_dres;
      r_exp_mode <= r_exp_mode;
    end
  end

  // Sticky error flag and the mode of the first failing transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err            <= 1'b0;
      r_first_err_mode <= 2'b00;
    end else if (clear) begin
      r_err            <= 1'b0;
      r_first_err_mode <= 2'b00;
    end else if (w_inc_err && !r_err) begin
      r_err            <= 1'b1;
      r_first_err_mode <= r_exp_dres ? 2'b01 : r_exp_mode;
    end else begin
      r_err            <= r_err;
      r_first_err_mode <= r_first_err_mode;
    end
  end

  jk_sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (.clk(clk), .reset(reset), .clr(clear), .inc(w_inc_hold), .cnt(hold_cnt));
  jk_sat_counter #(.CNT_W(CNT_W)) u_rst_cnt  (.clk(clk), .reset(reset), .clr(clear), .inc(w_inc_rst),  .cnt(rst_cnt));
  jk_sat_counter #(.CNT_W(CNT_W)) u_set_cnt  (.clk(clk), .reset(reset), .clr(clear), .inc(w_inc_set),  .cnt(set_cnt));
  jk_sat_counter #(.CNT_W(CNT_W)) u_tog_cnt  (.clk(clk), .reset(reset), .clr(clear), .inc(w_inc_tog),  .cnt(tog_cnt));
  jk_sat_counter #(.CNT_W(CNT_W)) u_dres_cnt (.clk(clk), .reset(reset), .clr(clear), .inc(w_inc_dres), .cnt(dres_cnt));
  jk_sat_counter #(.CNT_W(CNT_W)) u_err_cnt  (.clk(clk), .reset(reset), .clr(clear), .inc(w_inc_err),  .cnt(err_cnt));

  assign err            = r_err;
  assign first_err_mode = r_first_err_mode;
  assign fail           = (r_state == FAIL);

endmodule

// File: tb/tb_jk_ff_checker.sv
// Bench for jk_ff_checker: two instances (wide counters / limit 1, 3-bit counters / limit 4)
// observe one reference JK flop whose Q can be inverted on demand, checked against a model.
module tb_jk_ff_checker;

  logic clk = 1'b0;
  logic reset, en, clear, dut_rst, J, K, fault;
  logic q_ff = 1'b0;
  logic q_drv;

  logic [15:0] a_cnt [6];
  logic [2:0]  b_cnt [6];
  logic        a_err, b_err, a_fail, b_fail;
  logic [1:0]  a_fem, b_fem;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state, index 0 = instance a, 1 = instance b.
  // Counter slots: 0 hold, 1 reset, 2 set, 3 toggle, 4 dut-reset, 5 error.
  int    m_cnt [2][6];
  bit    m_err [2];
  bit    m_fail [2];
  bit    m_valid [2];
  int    m_fem [2];
  bit    p_q [2];
  bit    p_dres [2];
  int    p_mode [2];
  int    m_max [2] = '{65535, 7};
  int    m_lim [2] = '{1, 4};
  string cname [6] = '{"hold", "rst", "set", "tog", "dres", "errc"};

  always #5 clk = ~clk;

  assign q_drv = fault ? ~q_ff : q_ff;

  // Observed JK flop with synchronous active-high reset.
  always_ff @(posedge clk) q_ff <= dut_rst ? 1'b0 : ((J & ~q_ff) | (~K & q_ff));

  jk_ff_checker #(.CNT_W(16), .ERR_LIMIT(1)) u_a (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .dut_rst(dut_rst), .J(J), .K(K), .Q(q_drv),
    .hold_cnt(a_cnt[0]), .rst_cnt(a_cnt[1]), .set_cnt(a_cnt[2]), .tog_cnt(a_cnt[3]),
    .dres_cnt(a_cnt[4]), .err_cnt(a_cnt[5]), .err(a_err), .first_err_mode(a_fem), .fail(a_fail));

  jk_ff_checker #(.CNT_W(3), .ERR_LIMIT(4)) u_b (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .dut_rst(dut_rst), .J(J), .K(K), .Q(q_drv),
    .hold_cnt(b_cnt[0]), .rst_cnt(b_cnt[1]), .set_cnt(b_cnt[2]), .tog_cnt(b_cnt[3]),
    .dres_cnt(b_cnt[4]), .err_cnt(b_cnt[5]), .err(b_err), .first_err_mode(b_fem), .fail(b_fail));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 6; k++) m_cnt[i][k] = 0;
      m_err[i] = 1'b0; m_fail[i] = 1'b0; m_valid[i] = 1'b0; m_fem[i] = 0;
      p_q[i] = 1'b0; p_dres[i] = 1'b0; p_mode[i] = 0;
    end
  endtask

  task automatic bump(input int i, input int k);
    if (m_cnt[i][k] < m_max[i]) m_cnt[i][k]++;
  endtask

  // One rising edge of the checker described by its rules, from the values it sampled.
  task automatic model_edge(input int i, input bit c_en, input bit c_clr, input bit c_rst,
                            input bit c_j, input bit c_k, input bit c_q);
    if (c_clr) begin
      for (int k = 0; k < 6; k++) m_cnt[i][k] = 0;
      m_err[i] = 1'b0; m_fem[i] = 0; m_fail[i] = 1'b0; m_valid[i] = 1'b0;
      p_q[i] = 1'b0; p_dres[i] = 1'b0; p_mode[i] = 0;
    end else if (!m_fail[i]) begin
      if (!c_en) begin
        m_valid[i] = 1'b0;
      end else begin
        if (m_valid[i]) begin
          if (c_q == p_q[i]) begin
            bump(i, p_dres[i] ? 4 : p_mode[i]);
          end else begin
            bump(i, 5);
            if (!m_err[i]) begin
              m_err[i] = 1'b1;
              m_fem[i] = p_dres[i] ? 1 : p_mode[i];
            end
            if (m_cnt[i][5] == m_lim[i]) m_fail[i] = 1'b1;
          end
        end
        if (!m_fail[i]) begin
          p_q[i]    = c_rst ? 1'b0 : ((c_j & ~c_q) | (~c_k & c_q));
          p_dres[i] = c_rst;
          p_mode[i] = 2 * int'(c_j) + int'(c_k);
          m_valid[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk_all();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("a_%s", cname[k]), 32'(a_cnt[k]), 32'(m_cnt[0][k]));
      chk($sformatf("b_%s", cname[k]), 32'(b_cnt[k]), 32'(m_cnt[1][k]));
    end
    chk("a_err", 32'(a_err), 32'(m_err[0]));
    chk("b_err", 32'(b_err), 32'(m_err[1]));
    chk("a_fem", 32'(a_fem), 32'(m_fem[0]));
    chk("b_fem", 32'(b_fem), 32'(m_fem[1]));
    chk("a_fail", 32'(a_fail), 32'(m_fail[0]));
    chk("b_fail", 32'(b_fail), 32'(m_fail[1]));
  endtask

  task automatic step();
    bit s_en, s_clr, s_rst, s_j, s_k, s_q;
    #1;
    s_en = en; s_clr = clear; s_rst = dut_rst; s_j = J; s_k = K; s_q = q_drv;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, s_en, s_clr, s_rst, s_j, s_k, s_q);
    #1;
    chk_all();
    @(negedge clk);
  endtask

  task automatic go(input bit e, input bit c, input bit r, input bit j, input bit k, input bit f);
    en = e; clear = c; dut_rst = r; J = j; K = k; fault = f;
    step();
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; clear = 1'b0; dut_rst = 1'b0; J = 1'b0; K = 1'b0; fault = 1'b0;
    model_reset();
    @(negedge clk);
    chk_all();
    chk("reset_fail", 32'(a_fail), 32'd0);
    reset = 1'b1;

    // One DUT-reset cycle then HOLD, RESET, SET, TOGGLE, TOGGLE.
    go(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_dres", 32'(a_cnt[4]), 32'd1);
    chk("t1_hold", 32'(a_cnt[0]), 32'd1);
    chk("t1_rst",  32'(a_cnt[1]), 32'd1);
    chk("t1_set",  32'(a_cnt[2]), 32'd1);
    chk("t1_tog",  32'(a_cnt[3]), 32'd2);
    chk("t1_errc", 32'(a_cnt[5]), 32'd0);
    chk("t1_err",  32'(a_err),    32'd0);

    // Toggles with Q inverted (to 0) on the compare of a toggle expected to give 1.
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t2_errc", 32'(a_cnt[5]), 32'd1);
    chk("t2_err",  32'(a_err),    32'd1);
    chk("t2_fem",  32'(a_fem),    32'd3);
    chk("t2_fail", 32'(a_fail),   32'd1);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    go(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_frozen_hold", 32'(a_cnt[0]), 32'd2);
    chk("t2_frozen_tog",  32'(a_cnt[3]), 32'd3);
    chk("t2_frozen_errc", 32'(a_cnt[5]), 32'd1);
    chk("t2_frozen_fail", 32'(a_fail),   32'd1);

    // HOLD run saturates the 3-bit counters of instance b.
    for (int n = 0; n < 10; n++) go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_b_hold", 32'(b_cnt[0]), 32'd7);

    // Clear out of FAIL, then one edge with no count, then counting resumes.
    go(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_errc", 32'(a_cnt[5]), 32'd0);
    chk("t4_hold", 32'(a_cnt[0]), 32'd0);
    chk("t4_err",  32'(a_err),    32'd0);
    chk("t4_fail", 32'(a_fail),   32'd0);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_prime_hold", 32'(a_cnt[0]), 32'd0);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_resume_hold", 32'(a_cnt[0]), 32'd1);

    // Enable gap of two cycles during TOGGLE.
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_tog_pre", 32'(a_cnt[3]), 32'd2);
    go(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_tog_gap", 32'(a_cnt[3]), 32'd2);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_tog_prime", 32'(a_cnt[3]), 32'd2);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_tog_resume", 32'(a_cnt[3]), 32'd3);

    // Short asynchronous checker reset between edges.
    reset = 1'b0;
    #2;
    model_reset();
    chk_all();
    chk("t6_async_tog", 32'(a_cnt[3]), 32'd0);
    chk("t6_async_hold", 32'(a_cnt[0]), 32'd0);
    #1;
    reset = 1'b1;
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_first_edge", 32'(a_cnt[3]), 32'd0);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_second_edge", 32'(a_cnt[3]), 32'd1);

    // Randomized traffic with occasional faults, enable drops and clears.
    for (int n = 0; n < 400; n++) begin
      go(($urandom_range(0, 9) != 0),
         ($urandom_range(0, 99) < (m_fail[0] ? 30 : 2)),
         ($urandom_range(0, 9) == 0),
         1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)),
         ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
